mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the 32x32-bit register memory between two requesters, A and B, using round-robin arbitration with valid/ready handshakes.
- Drives the memory's mode, write-enable, address and write-data inputs, and returns read data to the requester that issued the read.
- Contains a clear sequencer that walks every word to zero on request.
- Sits directly in front of the memory; the memory has no other master.

Parameters:
- DEPTH, 32, number of memory words; address width is log2(DEPTH) = 5.
- WIDTH, 32, data width.
- MEM_LAT, 2, cycles from the issue edge to valid read data on mem_data_out.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- a_valid, b_valid  in  1  request valid, per port
- a_ready, b_ready  out  1  request accepted this cycle (combinational)
- a_we, b_we  in  1  1 = write, 0 = read
- a_addr, b_addr  in  5  word address
- a_wdata, b_wdata  in  32  write data
- a_rvalid, b_rvalid  out  1  read response valid, one-cycle pulse
- a_rdata, b_rdata  out  32  read response data
- clr_start  in  1  pulse that requests a full clear
- clr_busy  out  1  high while the clear sequence runs
- clr_done  out  1  one-cycle pulse after the last clear write
- mem_mode  out  1  1 = memory write-protected; 0 = writes allowed
- mem_write_enable  out  1  memory write strobe
- mem_address  out  5  memory address
- mem_data_in  out  32  memory write data
- mem_data_out  in  32  memory read data

Behaviour:
- States: SERVE, CLEAR, DONE. Reset enters SERVE.
- Reset values:
  - all ready, rvalid and clr outputs = 0; rdata = 0
  - mem_mode = 1, mem_write_enable = 0, mem_address = 0, mem_data_in = 0
  - last_grant = B, so A wins the first contention
  - response pipeline emptied; in-flight responses are dropped and never issued
- Arbitration (SERVE only):
  - Only one valid: that port is granted.
  - Both valid: the port not equal to last_grant is granted.
  - Grant drives the port's ready combinationally in the same cycle.
  - A transfer is valid && ready; last_grant updates only on a transfer.
  - At most one transfer per cycle. Requesters hold valid and payload until ready.
- Memory drive (combinational from the granted request):
  - Write: mem_mode = 0, mem_write_enable = 1, address and data from the request.
  - Read: mem_mode = 1, mem_write_enable = 0, mem_address = request address.
  - Idle: mem_mode = 1, mem_write_enable = 0, address and data = 0.
- Response tracking:
  - A shift register of MEM_LAT entries holds {valid, port}; each accepted read pushes an entry.
  - A read accepted in cycle t produces x_rvalid = 1 in cycle t + MEM_LAT, with x_rdata = mem_data_out, on the issuing port only.
  - Writes produce no response.
  - Back-to-back reads give back-to-back responses in issue order.
- Clear sequencer:
  - clr_start seen in SERVE moves to CLEAR on the next edge; a transfer accepted in that same cycle still completes normally.
  - CLEAR:
    - Both ready = 0.
    - Counter 0..31 drives mem_address; mem_mode = 0, mem_write_enable = 1, mem_data_in = 0.
    - Exactly 32 cycles; clr_busy = 1 throughout.
  - After the address-31 write, go to DONE: clr_done = 1 for one cycle, ready = 0, then return to SERVE.
  - clr_start is ignored in CLEAR and DONE.
  - Read responses already in flight still return during CLEAR.
- Reset asserted mid-CLEAR aborts the clear: no clr_done; next state is SERVE.
- Read-after-write to the same address, issued in consecutive cycles, returns the new data.

Test Plan:
- Reset, then A writes addr 3 = 0xDEADBEEF; A reads addr 3 → a_rvalid exactly 2 cycles after the read handshake, a_rdata = 0xDEADBEEF, b_rvalid stays 0.
- A and B both hold valid reads of addr 1 and 2 for 4 cycles → grants alternate A, B, A, B; responses return in the same order on the matching ports.
- Only B valid for 3 cycles with A idle → B granted every cycle; when A then asserts alongside B, A wins the next grant.
- Fill addr 0..31 with addr+1, pulse clr_start → exactly 32 write cycles with clr_busy = 1 and both ready = 0, then one clr_done pulse; reads of all 32 words return 0.
- Issue a read, then pulse clr_start in the following cycle → the read response still arrives with the pre-clear data.
- Assert reset on cycle 10 of CLEAR → no clr_done, all outputs at reset values, and the arbiter resumes with A priority.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester, clear-control and memory-side signals of the two-port memory arbiter.
// The arbiter takes the slave view; requesters and the memory sit on the master view.
interface mem_port_arbiter_if #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32
);
   localparam int AW = $clog2(DEPTH);

   logic             a_valid, a_ready, a_we, a_rvalid;
   logic [AW-1:0]    a_addr;
   logic [WIDTH-1:0] a_wdata, a_rdata;

   logic             b_valid, b_ready, b_we, b_rvalid;
   logic [AW-1:0]    b_addr;
   logic [WIDTH-1:0] b_wdata, b_rdata;

   logic             clr_start, clr_busy, clr_done;

   logic             mem_mode, mem_write_enable;
   logic [AW-1:0]    mem_address;
   logic [WIDTH-1:0] mem_data_in, mem_data_out;

   modport slave (
      input  a_valid, a_we, a_addr, a_wdata,
      input  b_valid, b_we, b_addr, b_wdata,
      input  clr_start, mem_data_out,
      output a_ready, a_rvalid, a_rdata,
      output b_ready, b_rvalid, b_rdata,
      output clr_busy, clr_done,
      output mem_mode, mem_write_enable, mem_address, mem_data_in
   );

   modport master (
      output a_valid, a_we, a_addr, a_wdata,
      output b_valid, b_we, b_addr, b_wdata,
      output clr_start, mem_data_out,
      input  a_ready, a_rvalid, a_rdata,
      input  b_ready, b_rvalid, b_rdata,
      input  clr_busy, clr_done,
      input  mem_mode, mem_write_enable, mem_address, mem_data_in
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one register memory between requesters A and B,
// with read-response routing and a sequencer that clears every word to zero.
module mem_port_arbiter #(
   parameter int DEPTH   = 32,
   parameter int WIDTH   = 32,
   parameter int MEM_LAT = 2
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {SERVE, CLEAR, DONE} state_t;
   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;
   typedef struct packed {
      logic  valid;
      port_t port;
   } resp_t;

   state_t           state;
   port_t            last_grant;
   logic [AW-1:0]    clr_cnt;
   logic             clr_busy_q, clr_done_q;
   resp_t            resp_pipe [MEM_LAT];
   resp_t            head;

   logic             grant_a, grant_b, xfer, xfer_we;
   logic [AW-1:0]    xfer_addr;
   logic [WIDTH-1:0] xfer_wdata;
   logic             a_rvalid, b_rvalid;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!reset && state == SERVE) begin
         if (bus.a_valid && bus.b_valid) begin
            grant_a = (last_grant == PORT_B);
            grant_b = (last_grant == PORT_A);
         end else begin
            grant_a = bus.a_valid;
            grant_b = bus.b_valid;
         end
      end
   end

   assign xfer       = grant_a || grant_b;
   assign xfer_we    = grant_b ? bus.b_we    : bus.a_we;
   assign xfer_addr  = grant_b ? bus.b_addr  : bus.a_addr;
   assign xfer_wdata = grant_b ? bus.b_wdata : bus.a_wdata;

   assign bus.a_ready = grant_a;
   assign bus.b_ready = grant_b;

   // Clear writes own the memory; otherwise the granted request drives it directly.
   always_comb begin
      bus.mem_mode         = 1'b1;
      bus.mem_write_enable = 1'b0;
      bus.mem_address      = '0;
      bus.mem_data_in      = '0;
      if (!reset && state == CLEAR) begin
         bus.mem_mode         = 1'b0;
         bus.mem_write_enable = 1'b1;
         bus.mem_address      = clr_cnt;
      end else if (xfer) begin
         bus.mem_address = xfer_addr;
         if (xfer_we) begin
            bus.mem_mode         = 1'b0;
            bus.mem_write_enable = 1'b1;
            bus.mem_data_in      = xfer_wdata;
         end
      end
   end

   assign head         = resp_pipe[MEM_LAT-1];
   assign a_rvalid     = !reset && head.valid && head.port == PORT_A;
   assign b_rvalid     = !reset && head.valid && head.port == PORT_B;
   assign bus.a_rvalid = a_rvalid;
   assign bus.b_rvalid = b_rvalid;
   assign bus.a_rdata  = a_rvalid ? bus.mem_data_out : '0;
   assign bus.b_rdata  = b_rvalid ? bus.mem_data_out : '0;
   assign bus.clr_busy = clr_busy_q;
   assign bus.clr_done = clr_done_q;

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SERVE;
         last_grant <= PORT_B;
         clr_cnt    <= '0;
         clr_busy_q <= 1'b0;
         clr_done_q <= 1'b0;
         // NOTE: the response pipeline is reset so stale in-flight reads never pulse rvalid.
         for (int i = 0; i < MEM_LAT; i++) resp_pipe[i] <= '0;
      end else begin
         resp_pipe[0] <= '{valid: xfer && !xfer_we, port: grant_b ? PORT_B : PORT_A};
         for (int i = 1; i < MEM_LAT; i++) resp_pipe[i] <= resp_pipe[i-1];
         if (xfer) last_grant <= grant_b ? PORT_B : PORT_A;
         clr_done_q <= 1'b0;
         case (state)
            SERVE: begin
               if (bus.clr_start) begin
                  state      <= CLEAR;
                  clr_cnt    <= '0;
                  clr_busy_q <= 1'b1;
               end
            end
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == AW'(DEPTH - 1)) begin
                  state      <= DONE;
                  clr_busy_q <= 1'b0;
                  clr_done_q <= 1'b1;
               end
            end
            DONE:    state <= SERVE;
            default: state <= SERVE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter against a transaction-level
// model: grant rules, shadow memory contents and a queue of due read responses.
module tb_mem_port_arbiter;
   localparam int DEPTH   = 32;
   localparam int WIDTH   = 32;
   localparam int MEM_LAT = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
   mem_port_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MEM_LAT(MEM_LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // External register memory: address captured at the issue edge, data one edge later.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [4:0]       rd_addr_q;
   logic [WIDTH-1:0] mem_rdata_q;
   always @(posedge clk) begin
      if (bus.mem_write_enable && !bus.mem_mode) mem[bus.mem_address] <= bus.mem_data_in;
      rd_addr_q   <= bus.mem_address;
      mem_rdata_q <= mem[rd_addr_q];
   end
   assign bus.mem_data_out = mem_rdata_q;

   // Reference model state
   typedef struct {
      int          due;
      bit          port_b;
      logic [31:0] data;
   } exp_resp_t;

   exp_resp_t   rq[$];
   logic [31:0] shadow [DEPTH];
   bit          last_b;
   int          clr_idx;
   bit          done_flag;
   int          cyc;
   bit          g_a, g_b, x_we;
   logic [4:0]  x_addr;
   logic [31:0] x_wdata;
   bit          chk_en;
   logic        obs_a_ready, obs_b_ready, obs_busy, obs_done, obs_a_rvalid;
   logic [31:0] obs_a_rdata;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic eval_check();
      bit          serving, e_mode, e_we, e_ra, e_rb;
      logic [4:0]  e_addr;
      logic [31:0] e_wd, e_rd;
      serving = !reset && clr_idx < 0 && !done_flag;
      g_a     = serving && bus.a_valid && (!bus.b_valid || last_b);
      g_b     = serving && bus.b_valid && !g_a;
      x_we    = g_b ? bus.b_we    : bus.a_we;
      x_addr  = g_b ? bus.b_addr  : bus.a_addr;
      x_wdata = g_b ? bus.b_wdata : bus.a_wdata;

      e_mode = 1'b1; e_we = 1'b0; e_addr = '0; e_wd = '0;
      if (!reset && clr_idx >= 0) begin
         e_mode = 1'b0; e_we = 1'b1; e_addr = 5'(clr_idx);
      end else if (g_a || g_b) begin
         e_addr = x_addr;
         if (x_we) begin
            e_mode = 1'b0; e_we = 1'b1; e_wd = x_wdata;
         end
      end

      e_ra = 1'b0; e_rb = 1'b0; e_rd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
         if (!reset) begin
            e_ra = !rq[0].port_b;
            e_rb = rq[0].port_b;
            e_rd = rq[0].data;
         end
         void'(rq.pop_front());
      end

      obs_a_ready  = bus.a_ready;
      obs_b_ready  = bus.b_ready;
      obs_busy     = bus.clr_busy;
      obs_done     = bus.clr_done;
      obs_a_rvalid = bus.a_rvalid;
      obs_a_rdata  = bus.a_rdata;

      if (chk_en) begin
         check("a_ready",   32'(bus.a_ready),          32'(g_a));
         check("b_ready",   32'(bus.b_ready),          32'(g_b));
         check("mem_mode",  32'(bus.mem_mode),         32'(e_mode));
         check("mem_we",    32'(bus.mem_write_enable), 32'(e_we));
         check("mem_addr",  32'(bus.mem_address),      32'(e_addr));
         check("mem_wdata", bus.mem_data_in,           e_wd);
         check("a_rvalid",  32'(bus.a_rvalid),         32'(e_ra));
         check("b_rvalid",  32'(bus.b_rvalid),         32'(e_rb));
         check("a_rdata",   bus.a_rdata,               e_ra ? e_rd : 32'h0);
         check("b_rdata",   bus.b_rdata,               e_rb ? e_rd : 32'h0);
         check("clr_busy",  32'(bus.clr_busy),         32'(clr_idx >= 0));
         check("clr_done",  32'(bus.clr_done),         32'(done_flag));
      end
   endtask

   task automatic commit();
      if (reset) begin
         last_b    = 1'b1;
         clr_idx   = -1;
         done_flag = 1'b0;
         rq.delete();
      end else begin
         if (g_a || g_b) begin
            last_b = g_b;
            if (x_we) shadow[x_addr] = x_wdata;
            else rq.push_back('{due: cyc + MEM_LAT, port_b: g_b, data: shadow[x_addr]});
         end
         if (done_flag) begin
            done_flag = 1'b0;
         end else if (clr_idx >= 0) begin
            shadow[clr_idx] = '0;
            if (clr_idx == DEPTH - 1) begin
               clr_idx   = -1;
               done_flag = 1'b1;
            end else begin
               clr_idx++;
            end
         end else if (bus.clr_start) begin
            clr_idx = 0;
         end
      end
      cyc++;
   endtask

   task automatic cycle();
      @(negedge clk);
      eval_check();
      @(posedge clk);
      commit();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      idle(n);
      reset = 1'b0;
   endtask

   task automatic do_a(input bit we, input int addr, input logic [31:0] d);
      bus.a_valid = 1'b1; bus.a_we = we; bus.a_addr = 5'(addr); bus.a_wdata = d;
      for (int i = 0; i < 40; i++) begin
         cycle();
         if (g_a) begin
            bus.a_valid = 1'b0;
            return;
         end
      end
      check("a_req_timeout", 32'd1, 32'd0);
      bus.a_valid = 1'b0;
   endtask

   initial begin
      int busy_cnt, done_cnt, rdy_cnt;
      logic [31:0] seen;

      reset = 1'b1;
      bus.a_valid = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_valid = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
      bus.clr_start = 0;
      last_b = 1'b1; clr_idx = -1; done_flag = 1'b0; cyc = 0; chk_en = 1'b0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = 'x;
      #1;
      cycle();
      chk_en = 1'b1;
      idle(2);
      reset = 1'b0;

      // Write then read back on A
      do_a(1'b1, 3, 32'hDEADBEEF);
      do_a(1'b0, 3, 32'h0);
      idle(3);

      // Fill every word with addr+1
      for (int i = 0; i < DEPTH; i++) do_a(1'b1, i, 32'(i + 1));
      idle(2);

      // Contention alternates, starting with A after reset
      do_reset(1);
      bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 5'd1;
      bus.b_valid = 1; bus.b_we = 0; bus.b_addr = 5'd2;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check("alt_grant_b", 32'(obs_b_ready), 32'(i % 2));
      end
      bus.a_valid = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("b_only_grant", 32'(obs_b_ready), 32'd1);
      end
      bus.a_valid = 1;
      cycle();
      check("a_wins_after_b", 32'(obs_a_ready), 32'd1);
      bus.a_valid = 0; bus.b_valid = 0;
      idle(3);

      // Full clear with B held waiting
      bus.clr_start = 1;
      cycle();
      bus.clr_start = 0;
      bus.b_valid = 1; bus.b_we = 0; bus.b_addr = 5'd7;
      busy_cnt = 0; done_cnt = 0; rdy_cnt = 0;
      for (int i = 0; i < 36; i++) begin
         cycle();
         busy_cnt += int'(obs_busy);
         done_cnt += int'(obs_done);
         if (obs_busy || obs_done) rdy_cnt += int'(obs_a_ready) + int'(obs_b_ready);
         if (g_b) bus.b_valid = 0;
      end
      check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
      check("clr_done_pulses", 32'(done_cnt), 32'd1);
      check("clr_ready_low",   32'(rdy_cnt),  32'd0);
      for (int i = 0; i < DEPTH; i++) do_a(1'b0, i, 32'h0);
      idle(3);

      // Read in flight across the start of a clear
      do_a(1'b1, 5, 32'h5555AAAA);
      bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 5'd5;
      cycle();
      bus.a_valid = 0;
      bus.clr_start = 1;
      cycle();
      bus.clr_start = 0;
      seen = '0;
      for (int i = 0; i < 36; i++) begin
         cycle();
         if (obs_a_rvalid) seen = obs_a_rdata;
      end
      check("read_before_clear", seen, 32'h5555AAAA);

      // Reset during the clear
      for (int i = 0; i < 4; i++) do_a(1'b1, 20 + i, 32'hA0 + 32'(i));
      bus.clr_start = 1;
      cycle();
      bus.clr_start = 0;
      idle(10);
      reset = 1'b1;
      idle(2);
      check("rst_busy", 32'(bus.clr_busy), 32'd0);
      check("rst_mode", 32'(bus.mem_mode), 32'd1);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         cycle();
         done_cnt += int'(obs_done);
      end
      check("no_done_after_reset", 32'(done_cnt), 32'd0);
      bus.a_valid = 1; bus.a_we = 0; bus.a_addr = 5'd21;
      bus.b_valid = 1; bus.b_we = 0; bus.b_addr = 5'd22;
      cycle();
      check("a_priority_after_reset", 32'(obs_a_ready), 32'd1);
      if (g_a) bus.a_valid = 0;
      cycle();
      bus.a_valid = 0; bus.b_valid = 0;
      idle(3);

      // Randomised traffic with occasional clears and resets
      for (int i = 0; i < 800; i++) begin
         if (!bus.a_valid || g_a) begin
            bus.a_valid = ($urandom_range(0, 2) != 0);
            bus.a_we    = 1'($urandom_range(0, 1));
            bus.a_addr  = 5'($urandom_range(0, DEPTH - 1));
            bus.a_wdata = $urandom;
         end
         if (!bus.b_valid || g_b) begin
            bus.b_valid = ($urandom_range(0, 2) != 0);
            bus.b_we    = 1'($urandom_range(0, 1));
            bus.b_addr  = 5'($urandom_range(0, DEPTH - 1));
            bus.b_wdata = $urandom;
         end
         bus.clr_start = ($urandom_range(0, 99) == 0);
         reset         = ($urandom_range(0, 299) == 0);
         cycle();
      end
      reset = 1'b0; bus.clr_start = 0; bus.a_valid = 0; bus.b_valid = 0;
      idle(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
